oled_iic_writer: RTL and testbench
==================================

Name: oled_iic_writer

Overview:
- Write-only I2C master serving the OLED font/command generators.
- Accepts one 24-bit word `{slave_addr[7:0], control[7:0], data[7:0]}` under a level request and serialises it as a single I2C frame: START, 3 bytes each with an ACK slot, STOP.
- Pulses `write_done` once per frame so the upstream generator can advance its index and present the next word.
- Sits between the OLED display-content generators and the board SCL/SDA pins.

Parameters:
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- IIC_FREQ, 400_000: SCL frequency in Hz.
- DIV (localparam) = CLK_FREQ/(4*IIC_FREQ), truncated, minimum 1: sys_clk cycles per SCL quarter-period. Default value is 31.

Ports:
- sys_clk, input, 1: sole clock.
- sys_rst, input, 1: synchronous reset, active-high.
- iic_req, input, 1: level request; a frame is wanted while high.
- iic_data, input, 24: word to send, MSB first, byte order [23:16], [15:8], [7:0].
- write_done, output, 1: one-cycle pulse when a frame has finished.
- busy, output, 1: high from acceptance until the write_done cycle, inclusive.
- iic_scl, output, 1: SCL, push-pull.
- iic_sda_oe, output, 1: 1 pulls SDA low; 0 releases it (external pull-up).
- iic_sda_i, input, 1: SDA pin sampled value.
- ack_err, output, 1: one-cycle NACK flag, coincident with write_done.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high (sys_rst).
- Reset values: state=IDLE, iic_scl=1, iic_sda_oe=0, write_done=0, busy=0, ack_err=0, quarter counter=0, divider=0.
- Reset mid-frame: return to IDLE on the next edge. SCL high, SDA released, no write_done pulse.
- States: IDLE, START, BYTE, ACK, STOP, DONE.
- IDLE: iic_scl=1, iic_sda_oe=0. If iic_req=1 at an edge, latch iic_data into a shift register, clear byte count and bit count, go to START, set busy=1.
- Timing: every non-IDLE/DONE state advances in quarters of DIV cycles. Divider counts 0..DIV-1; the quarter index q advances at DIV-1.
- START:
  - q0: SCL=1, SDA released.
  - q1–q2: SCL=1, SDA low.
  - q3: SCL=0, SDA low.
  - Then go to BYTE, bit 7.
- BYTE (per bit):
  - q0: SCL=0, SDA = current bit (bit 0 drives low, bit 1 releases).
  - q1–q2: SCL=1.
  - q3: SCL=0.
  - Shift left after q3. After 8 bits go to ACK.
- ACK:
  - SDA released in all quarters.
  - SCL: q0=0, q1–q2=1, q3=0.
  - After q3: byte count<2 → BYTE for the next byte; otherwise → STOP.
- STOP:
  - q0: SCL=0, SDA low.
  - q1: SCL=1, SDA low.
  - q2–q3: SCL=1, SDA released.
  - Then go to DONE.
- DONE: exactly one cycle. write_done=1, busy=1. Then IDLE.
- Frame length: 4+27×4+4 = 116 quarters. With the accepting edge as cycle 0, write_done is high in cycle 116×DIV.
- Back-to-back frames: iic_data is re-sampled in IDLE after DONE, so the upstream may update iic_data on the edge where it sees write_done. With iic_req held high, the next START begins 1 cycle after DONE. The minimum bus idle between frames is 1 cycle plus the STOP q2–q3 hold.
- iic_data and iic_req changes during a frame are ignored.
- iic_req dropping mid-frame does not abort the frame.
- SDA changes only while SCL=0, except inside START and STOP.

Optional Feature:
- Macro: IIC_ACK_CHECK_EN.
- Defined:
  - iic_sda_i is sampled on the first cycle of ACK q2.
  - Sampled 1 (NACK): after that ACK's q3, skip any remaining bytes and go to STOP.
  - In DONE: ack_err=1 together with write_done=1.
  - Sampled 0: normal flow.
- Undefined: iic_sda_i is unused, ack_err is tied 0, and every frame is 116 quarters.

Test Plan:
- Reset/idle: assert sys_rst for 3 cycles, release, iic_req=0 for 100 cycles → iic_scl=1, iic_sda_oe=0, busy=0, write_done never high.
- Single frame, CLK_FREQ=1600, IIC_FREQ=100 (DIV=4), iic_data=24'h7800AF, slave ACKs → bus decoder sees START, bytes 0x78, 0x00, 0xAF, STOP. write_done high only in cycle 464 after acceptance. ack_err=0.
- Back-to-back: iic_req held high; upstream swaps iic_data 24'h7840FF → 24'h784055 on write_done → second START 1 cycle after the first write_done; decoded bytes 0x78, 0x40, 0x55. Exactly two write_done pulses over 2×465 cycles.
- Mid-frame input change: change iic_data and drop iic_req during the second byte → transmitted bytes are unchanged and the frame completes with one write_done.
- Reset mid-frame: assert sys_rst during byte 1, bit 3 → next cycle iic_scl=1, iic_sda_oe=0, busy=0; no write_done pulse.
- NACK (IIC_ACK_CHECK_EN defined): slave NACKs the address byte → STOP follows the first ACK slot. write_done=1 and ack_err=1 in the same cycle, at cycle (4+36+4)×4 = 176 after acceptance.

Source files
------------

// File: rtl/oled_iic_writer.sv
// Write-only I2C master: sends one {addr, control, data} word per request as START, 3 bytes + ACK slots, STOP.
// Define IIC_ACK_CHECK_EN to sample slave ACKs, end the frame early on a NACK and flag it on ack_err.
module oled_iic_writer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 400_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        iic_req,
  input  logic [23:0] iic_data,
  output logic        write_done,
  output logic        busy,
  output logic        iic_scl,
  output logic        iic_sda_oe,
  input  logic        iic_sda_i,
  output logic        ack_err
);
  localparam int DIV_RAW = CLK_FREQ / (4 * IIC_FREQ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shift_q, shift_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          nack_q, nack_d;
  logic          qtr_end;
  logic          frame_end;

`ifndef IIC_ACK_CHECK_EN
  logic unused_sda;
  assign unused_sda = iic_sda_i;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    busy_d   = busy_q;
    nack_d   = nack_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    qtr_end  = (div_q == DW'(DIV - 1));
    frame_end = qtr_end && (qtr_q == 2'd3);

    if (state_q != S_IDLE && state_q != S_DONE) begin
      div_d = qtr_end ? '0 : div_q + DW'(1);
      if (qtr_end) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (iic_req) begin
          shift_d = iic_data;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          nack_d  = 1'b0;
          div_d   = '0;
          qtr_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (frame_end) begin
          bit_d   = 3'd0;
          state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        if (frame_end) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_q == 3'd7) state_d = S_ACK;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_ACK: begin
`ifdef IIC_ACK_CHECK_EN
        // Sample once, mid-way through SCL high, when the slave's level is stable.
        if (qtr_q == 2'd2 && div_q == '0) nack_d = nack_q | iic_sda_i;
`endif
        if (frame_end) begin
          if (byte_q == 2'd2 || nack_q) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd0;
            state_d = S_BYTE;
          end
        end
      end
      S_STOP: begin
        if (frame_end) begin
          done_d  = 1'b1;
`ifdef IIC_ACK_CHECK_EN
          err_d   = nack_q;
`endif
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Bus levels follow the state/quarter being entered so the pins are registered.
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      S_START: begin
        scl_d    = (qtr_d != 2'd3);
        sda_oe_d = (qtr_d != 2'd0);
      end
      S_BYTE: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = ~shift_d[23];
      end
      S_ACK: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = 1'b0;
      end
      S_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd1);
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      shift_q  <= 24'd0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      nack_q   <= nack_d;
    end
  end

  assign write_done = done_q;
  assign busy       = busy_q;
  assign iic_scl    = scl_q;
  assign iic_sda_oe = sda_oe_q;
  assign ack_err    = err_q;
endmodule

// File: tb/tb_oled_iic_writer.sv
// Bench for oled_iic_writer: I2C bus decoder + ACKing slave, vector table, random frames, corner sequences.
module tb_oled_iic_writer;
  localparam int CLK_FREQ = 1600;
  localparam int IIC_FREQ = 100;
  localparam int DIV      = 4;
  localparam int FULL_CYC = 116 * DIV;
  localparam int NVEC     = 12;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        iic_req = 1'b0;
  logic [23:0] iic_data = 24'd0;
  logic        write_done, busy, iic_scl, iic_sda_oe, ack_err;
  logic        slave_pull = 1'b0;
  logic        iic_sda_i;

  assign iic_sda_i = ~iic_sda_oe & ~slave_pull;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  oled_iic_writer #(.CLK_FREQ(CLK_FREQ), .IIC_FREQ(IIC_FREQ)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .iic_req    (iic_req),
    .iic_data   (iic_data),
    .write_done (write_done),
    .busy       (busy),
    .iic_scl    (iic_scl),
    .iic_sda_oe (iic_sda_oe),
    .iic_sda_i  (iic_sda_i),
    .ack_err    (ack_err)
  );

  // Bus decoder and slave: counts START/STOP, collects bytes, ACKs every byte except nack_byte.
  logic [7:0] got_q[$];
  logic       got_ack_q[$];
  int         starts = 0, stops = 0, bit_cnt = 0, byte_idx = 0, done_pulses = 0;
  int         nack_byte = 3;
  logic [8:0] sh = 9'd0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge sys_clk) begin : bus_mon
    logic sda_now;
    sda_now = iic_sda_i;
    if (write_done) done_pulses++;
    if (sys_rst) begin
      bit_cnt    = 0;
      slave_pull = 1'b0;
    end else if (iic_scl && prev_scl && prev_sda && !sda_now) begin
      starts++;
      bit_cnt  = 0;
      byte_idx = 0;
    end else if (iic_scl && prev_scl && !prev_sda && sda_now) begin
      stops++;
    end else if (iic_scl && !prev_scl) begin
      sh = {sh[7:0], sda_now};
      bit_cnt++;
      if (bit_cnt == 9) begin
        got_q.push_back(sh[8:1]);
        got_ack_q.push_back(sh[0]);
        bit_cnt = 0;
        byte_idx++;
      end
    end else if (!iic_scl && prev_scl) begin
      slave_pull = (bit_cnt == 8) && (byte_idx != nack_byte);
    end
    prev_scl = iic_scl;
    prev_sda = sda_now;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_bus;
    got_q.delete();
    got_ack_q.delete();
    starts = 0;
    stops  = 0;
  endtask

  task automatic accept(input logic [23:0] d);
    @(negedge sys_clk);
    iic_data = d;
    iic_req  = 1'b1;
    @(posedge sys_clk);
    #1;
    iic_req = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at, output logic err);
    at  = -1;
    err = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge sys_clk);
      #1;
      if (write_done) begin
        at  = i;
        err = ack_err;
        break;
      end
    end
  endtask

  // Reference model: bytes sent before STOP, given which byte the slave refuses.
  function automatic int model_nbytes(input int nack_at);
`ifdef IIC_ACK_CHECK_EN
    return (nack_at < 3) ? nack_at + 1 : 3;
`else
    return 3;
`endif
  endfunction

  function automatic logic model_err(input int nack_at);
`ifdef IIC_ACK_CHECK_EN
    return nack_at < 3;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_bytes(input string tag, input logic [23:0] d, input int n, input int nack_at);
    logic [7:0] eb;
    check({tag, "_nbytes"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      eb = 8'(d >> (16 - 8 * i));
      check($sformatf("%s_byte%0d", tag, i), got_q[i], eb);
      check($sformatf("%s_ack%0d", tag, i), got_ack_q[i], (i == nack_at));
    end
  endtask

  typedef struct {
    logic [23:0] data;
    int          nack_at;
    int          exp_cyc;
    logic        exp_err;
    int          exp_nbytes;
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    int   at;
    logic err;
    int   bad_scl, bad_oe, bad_busy, bad_done;
    int   pulses[$];
    logic busy_465, busy_466;
    int   pulses_before;

    vecs[0].data = 24'h7800AF; vecs[0].nack_at = 3;
    vecs[1].data = 24'h7840FF; vecs[1].nack_at = 3;
    vecs[2].data = 24'h780055; vecs[2].nack_at = 0;
    vecs[3].data = 24'hFF00FF; vecs[3].nack_at = 1;
    vecs[4].data = 24'h000000; vecs[4].nack_at = 2;
    vecs[5].data = 24'hFFFFFF; vecs[5].nack_at = 3;
    for (int i = 6; i < NVEC; i++) begin
      vecs[i].data    = 24'($urandom);
      vecs[i].nack_at = $urandom_range(0, 5);
      if (vecs[i].nack_at > 3) vecs[i].nack_at = 3;
    end
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].exp_nbytes = model_nbytes(vecs[i].nack_at);
      vecs[i].exp_cyc    = (4 + 36 * vecs[i].exp_nbytes + 4) * DIV;
      vecs[i].exp_err    = model_err(vecs[i].nack_at);
    end

    // Reset and idle
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("rst_scl", iic_scl, 1'b1);
    check("rst_sda_oe", iic_sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", write_done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    bad_scl = 0; bad_oe = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (iic_scl !== 1'b1) bad_scl++;
      if (iic_sda_oe !== 1'b0) bad_oe++;
      if (busy !== 1'b0) bad_busy++;
      if (write_done !== 1'b0) bad_done++;
    end
    check("idle_scl_bad_cycles", bad_scl, 0);
    check("idle_oe_bad_cycles", bad_oe, 0);
    check("idle_busy_bad_cycles", bad_busy, 0);
    check("idle_done_bad_cycles", bad_done, 0);

    // Vector table: single frames, with and without a refusing slave
    for (int v = 0; v < NVEC; v++) begin
      clear_bus();
      nack_byte = vecs[v].nack_at;
      accept(vecs[v].data);
      check($sformatf("v%0d_busy_after_accept", v), busy, 1'b1);
      wait_done(FULL_CYC + 20, at, err);
      check($sformatf("v%0d_done_cycle", v), at, vecs[v].exp_cyc);
      check($sformatf("v%0d_ack_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_busy_at_done", v), busy, 1'b1);
      @(posedge sys_clk);
      #1;
      check($sformatf("v%0d_busy_after_done", v), busy, 1'b0);
      check($sformatf("v%0d_done_one_cycle", v), write_done, 1'b0);
      check($sformatf("v%0d_starts", v), starts, 1);
      check($sformatf("v%0d_stops", v), stops, 1);
      check_bytes($sformatf("v%0d", v), vecs[v].data, vecs[v].exp_nbytes, vecs[v].nack_at);
      repeat ($urandom_range(1, 5)) @(posedge sys_clk);
    end
    nack_byte = 3;

    // Back-to-back frames with iic_req held high
    clear_bus();
    pulses.delete();
    busy_465 = 1'b0;
    busy_466 = 1'b0;
    @(negedge sys_clk);
    iic_data = 24'h7840FF;
    iic_req  = 1'b1;
    @(posedge sys_clk);
    #1;
    for (int c = 1; c <= 945; c++) begin
      @(posedge sys_clk);
      #1;
      if (c == 465) busy_465 = busy;
      if (c == 466) busy_466 = busy;
      if (write_done) begin
        pulses.push_back(c);
        iic_data = 24'h784055;
        if (pulses.size() == 2) iic_req = 1'b0;
      end
    end
    iic_req = 1'b0;
    check("b2b_pulse_count", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      check("b2b_first_done", pulses[0], FULL_CYC);
      check("b2b_second_done", pulses[1], 2 * FULL_CYC + 2);
    end
    check("b2b_idle_gap_busy", busy_465, 1'b0);
    check("b2b_second_accept_busy", busy_466, 1'b1);
    check("b2b_starts", starts, 2);
    check("b2b_stops", stops, 2);
    check("b2b_nbytes", got_q.size(), 6);
    if (got_q.size() == 6) begin
      check("b2b_b0", got_q[0], 8'h78);
      check("b2b_b1", got_q[1], 8'h40);
      check("b2b_b2", got_q[2], 8'hFF);
      check("b2b_b3", got_q[3], 8'h78);
      check("b2b_b4", got_q[4], 8'h40);
      check("b2b_b5", got_q[5], 8'h55);
    end

    // Input changes mid-frame are ignored
    repeat (3) @(posedge sys_clk);
    clear_bus();
    pulses_before = done_pulses;
    @(negedge sys_clk);
    iic_data = 24'h3C5AA5;
    iic_req  = 1'b1;
    @(posedge sys_clk);
    #1;
    at = -1;
    for (int c = 1; c <= FULL_CYC + 20; c++) begin
      @(posedge sys_clk);
      #1;
      if (c == 200) begin
        iic_data = 24'hC3A55A;
        iic_req  = 1'b0;
      end
      if (write_done && at < 0) at = c;
    end
    check("mid_done_cycle", at, FULL_CYC);
    check("mid_done_pulses", done_pulses - pulses_before, 1);
    check("mid_starts", starts, 1);
    check_bytes("mid", 24'h3C5AA5, 3, 3);

    // Reset during byte 1, bit 3
    clear_bus();
    pulses_before = done_pulses;
    accept(24'hA5C33C);
    repeat (228) @(posedge sys_clk);
    #1;
    check("rstmid_busy_before", busy, 1'b1);
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("rstmid_scl", iic_scl, 1'b1);
    check("rstmid_sda_oe", iic_sda_oe, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", write_done, 1'b0);
    repeat (FULL_CYC) @(posedge sys_clk);
    #1;
    check("rstmid_no_done_pulse", done_pulses - pulses_before, 0);
    check("rstmid_idle_scl", iic_scl, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
